// File: rtl/cifra_xor_stream.sv
// Streaming multi-word XOR cipher, ECB or chained, one key segment per cycle.
// Optional key rotation per word: define CIFRA_KEY_ROTATE_EN.
module cifra_xor_stream #(
   parameter int tamanho_key     = 8,
   parameter int tamanho_palavra = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [tamanho_key-1:0]     key,
   input  logic [tamanho_palavra-1:0] iv,
   input  logic                       mode,
   input  logic                       decrypt,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_last,
   input  logic [tamanho_palavra-1:0] plaintext,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [tamanho_palavra-1:0] ciphertext,
   output logic                       done
);

   localparam int NSEG = tamanho_palavra / tamanho_key;
   localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [SW-1:0] LAST_SEG = SW'(NSEG - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCEPT = 2'b01,
      PROC   = 2'b10,
      EMIT   = 2'b11
   } state_t;

   state_t current_state;

   logic [tamanho_key-1:0]     key_reg;
   logic [tamanho_palavra-1:0] chain_reg;
   logic [tamanho_palavra-1:0] work;
   logic [tamanho_palavra-1:0] orig;
   logic [tamanho_palavra-1:0] work_next;
   logic [SW-1:0]              seg;
   logic                       mode_reg;
   logic                       dec_reg;
   logic                       last_reg;

   // One segment per cycle, LSB segment first.
   always_comb begin
      work_next = work;
      work_next[seg*tamanho_key +: tamanho_key] =
         work[seg*tamanho_key +: tamanho_key] ^ key_reg ^
         (mode_reg ? chain_reg[seg*tamanho_key +: tamanho_key]
                   : {tamanho_key{1'b0}});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         current_state <= IDLE;
         key_reg       <= '0;
         chain_reg     <= '0;
         work          <= '0;
         orig          <= '0;
         seg           <= '0;
         mode_reg      <= 1'b0;
         dec_reg       <= 1'b0;
         last_reg      <= 1'b0;
         in_ready      <= 1'b0;
         out_valid     <= 1'b0;
         ciphertext    <= '0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (current_state)
            IDLE: begin
               if (start) begin
                  key_reg       <= key;
                  chain_reg     <= iv;
                  mode_reg      <= mode;
                  dec_reg       <= decrypt;
                  in_ready      <= 1'b1;
                  current_state <= ACCEPT;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  work          <= plaintext;
                  orig          <= plaintext;
                  last_reg      <= in_last;
                  seg           <= '0;
                  in_ready      <= 1'b0;
                  current_state <= PROC;
               end
            end
            PROC: begin
               work <= work_next;
               seg  <= seg + SW'(1);
               if (seg == LAST_SEG) begin
                  ciphertext    <= work_next;
                  out_valid     <= 1'b1;
                  current_state <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  // Decrypt chains on the ciphertext it was given.
                  chain_reg <= dec_reg ? orig : ciphertext;
`ifdef CIFRA_KEY_ROTATE_EN
                  key_reg <= {key_reg[tamanho_key-2:0],
                              key_reg[tamanho_key-1]};
`endif
                  out_valid <= 1'b0;
                  if (last_reg) begin
                     done          <= 1'b1;
                     current_state <= IDLE;
                  end else begin
                     in_ready      <= 1'b1;
                     current_state <= ACCEPT;
                  end
               end
            end
            default: current_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cifra_xor_stream.sv
// Self-checking bench for cifra_xor_stream: directed vectors plus random messages
// against a word-level reference model.
module tb_cifra_xor_stream;

   localparam int K    = 8;
   localparam int W    = 16;
   localparam int NSEG = W / K;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [K-1:0] key;
   logic [W-1:0] iv;
   logic         mode;
   logic         decrypt;
   logic         in_valid;
   logic         in_ready;
   logic         in_last;
   logic [W-1:0] plaintext;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] ciphertext;
   logic         done;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] msg [16];
   logic [W-1:0] got [16];

   cifra_xor_stream #(.tamanho_key(K), .tamanho_palavra(W)) dut (
      .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
      .mode(mode), .decrypt(decrypt), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .plaintext(plaintext),
      .out_valid(out_valid), .out_ready(out_ready),
      .ciphertext(ciphertext), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Word-level reference: c_i = p_i ^ {K_i,K_i} ^ (mode ? chain : 0).
   task automatic run_msg(input logic m, input logic d, input logic [K-1:0] k,
                          input logic [W-1:0] v, input int n, input int rnd,
                          input int hold, input logic poke);
      logic [W-1:0] chain, e, held, kb;
      logic [K-1:0] kr;
      int t, wt;
      chain = v;
      kr    = k;
      @(negedge clk);
      start = 1; key = k; iv = v; mode = m; decrypt = d;
      @(negedge clk);
      start = 0;
      key = K'($urandom); iv = W'($urandom);
      mode = 1'($urandom); decrypt = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!in_ready && t < 40) begin @(negedge clk); t++; end
         if (!in_ready) chk("ready_timeout", 0, 1);
         if (rnd != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
         in_valid = 1; plaintext = msg[i]; in_last = (i == n - 1);
         @(negedge clk);
         in_valid = 0; in_last = 1'($urandom); plaintext = W'($urandom);
         chk("ready_low", in_ready, 0);
         if (poke) begin start = 1; key = ~k; mode = ~m; iv = ~v; end
         t = 0;
         while (!out_valid && t < 40) begin @(negedge clk); t++; end
         start = 0;
         if (!out_valid) chk("valid_timeout", 0, 1);
         else if (rnd == 0) chk("latency", t, NSEG);
         kb = {NSEG{kr}};
         e  = msg[i] ^ kb ^ (m ? chain : '0);
         held = ciphertext;
         wt = (rnd != 0) ? int'($urandom_range(0, 3)) : hold;
         for (int j = 0; j < wt; j++) begin
            @(negedge clk);
            chk("bp_stable", ciphertext, held);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
         end
         chk("word", ciphertext, e);
         got[i] = ciphertext;
         out_ready = 1;
         @(negedge clk);
         out_ready = 0;
         chk("done", done, (i == n - 1));
         chain = d ? msg[i] : e;
`ifdef CIFRA_KEY_ROTATE_EN
         kr = {kr[K-2:0], kr[K-1]};
`endif
      end
      @(negedge clk);
      chk("done_pulse", done, 0);
   endtask

   initial begin
      reset = 1; start = 0; key = 0; iv = 0; mode = 0; decrypt = 0;
      in_valid = 0; in_last = 0; plaintext = 0; out_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ct", ciphertext, 0);
      chk("rst_done", done, 0);
      reset = 0;

      msg[0] = 16'h4848;
      run_msg(0, 0, 8'hFF, 16'h0, 1, 0, 0, 0);
      chk("ecb_enc", got[0], 16'hB7B7);

      msg[0] = 16'hB7B7;
      run_msg(0, 1, 8'hFF, 16'h0, 1, 0, 5, 0);
      chk("ecb_rt", got[0], 16'h4848);

      msg[0] = 16'h5555; msg[1] = 16'h0000;
      run_msg(1, 0, 8'h55, 16'h0, 2, 0, 0, 1);
      chk("cbc_enc0", got[0], 16'h0000);
      chk("cbc_enc1", got[1], 16'h5555);

      msg[0] = 16'h0000; msg[1] = 16'h5555;
      run_msg(1, 1, 8'h55, 16'h0, 2, 0, 0, 0);
      chk("cbc_dec0", got[0], 16'h5555);
      chk("cbc_dec1", got[1], 16'h0000);

      msg[0] = 16'h0000; msg[1] = 16'h0000;
      run_msg(0, 0, 8'h01, 16'h0, 2, 0, 0, 0);
      chk("rot0", got[0], 16'h0101);
`ifdef CIFRA_KEY_ROTATE_EN
      chk("rot1", got[1], 16'h0202);
`else
      chk("rot1", got[1], 16'h0101);
`endif

      // Reset while the word is in flight.
      @(negedge clk);
      start = 1; key = 8'hA5; mode = 1; iv = 16'h1234;
      @(negedge clk);
      start = 0; in_valid = 1; plaintext = 16'hBEEF; in_last = 0;
      @(negedge clk);
      in_valid = 0; reset = 1;
      @(negedge clk);
      reset = 0;
      chk("rproc_valid", out_valid, 0);
      chk("rproc_ct", ciphertext, 0);
      chk("rproc_done", done, 0);
      chk("rproc_ready", in_ready, 0);
      repeat (NSEG + 2) @(negedge clk);
      chk("rproc_idle_v", out_valid, 0);
      chk("rproc_idle_r", in_ready, 0);

      for (int r = 0; r < 25; r++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) msg[i] = W'($urandom);
         run_msg(1'($urandom), 1'($urandom), K'($urandom), W'($urandom),
                 n, 1, 0, 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
